// File: rtl/csr_arbiter.sv
// ----------------------------------------------------------------------------
// csr_arbiter
//
// Two-requester front end for a simple CSR register map. Requests are
// arbitrated round-robin, one transaction is in flight at a time, and the
// register-map strobes are generated with fixed hold times:
//   - write: write_en_o high for WR_HOLD cycles, then low for WR_HOLD cycles,
//            then a one-cycle response;
//   - read : read_en_o high for RD_HOLD cycles, data captured on the last of
//            them, then a one-cycle response carrying that data;
//   - out-of-range access: no strobe, immediate error response with all-ones
//            read data.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    [1:0] per-requester request valid
//   req_ready_o    [1:0] per-requester accept strobe (combinational, IDLE only)
//   req_write_i    [1:0] per-requester op, 1 = write, 0 = read
//   req_addr_i     [2*ADDR_WIDTH-1:0] requester n uses slice n
//   req_wdata_i    [2*DATA_WIDTH-1:0] requester n uses slice n
//   resp_valid_o   [1:0] one-cycle completion pulse to the owning requester
//   resp_err_o     error flag, meaningful while resp_valid_o is non-zero
//   resp_rdata_o   read data, meaningful while resp_valid_o is non-zero
//   addr_o         registered register-map address
//   write_data_o   registered register-map write data
//   write_en_o     registered register-map write enable
//   read_en_o      registered register-map read enable
//   read_data_i    register-map read data
// ----------------------------------------------------------------------------
module csr_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 12,
    parameter int NUM_STATUS_REG = 4,
    parameter int WR_HOLD        = 4,
    parameter int RD_HOLD        = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_write_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    output logic [1:0]              resp_valid_o,
    output logic                    resp_err_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   write_data_o,
    output logic                    write_en_o,
    output logic                    read_en_o,
    input  logic [DATA_WIDTH-1:0]   read_data_i
);

    // Hold counter is sized for the longer of the two hold phases and counts
    // down from HOLD-1 to zero, so a phase lasts exactly HOLD cycles.
    localparam int MAX_HOLD = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_HOLD - 1);

    // Range limits carry one extra bit so a map that fills the whole address
    // space still compares correctly.
    localparam logic [ADDR_WIDTH:0] WR_LIMIT = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG);
    localparam logic [ADDR_WIDTH:0] RD_LIMIT = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG + NUM_STATUS_REG);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        RD    = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  last_q,       last_d;
    logic                  owner_q,      owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  write_en_q,   write_en_d;
    logic                  read_en_q,    read_en_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic                  resp_err_q,   resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic                  grant_valid;
    logic                  grant_idx;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wr_ok;
    logic                  sel_rd_ok;

    // Round-robin grant. With both requesters valid the one not served last
    // wins; with a single requester valid it wins outright. Ready is only
    // offered in IDLE and never while reset is being applied, so nothing can
    // be accepted on a reset edge.
    always_comb begin
        grant_valid = (state_q == IDLE) && (|req_valid_i) && !rst_i;
        grant_idx   = (&req_valid_i) ? ~last_q : req_valid_i[1];
        req_ready_o = grant_valid ? (2'b01 << grant_idx) : 2'b00;

        sel_write   = grant_idx ? req_write_i[1] : req_write_i[0];
        sel_addr    = grant_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : req_addr_i[ADDR_WIDTH-1:0];
        sel_wdata   = grant_idx ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                : req_wdata_i[DATA_WIDTH-1:0];

        sel_wr_ok   = {1'b0, sel_addr} < WR_LIMIT;
        sel_rd_ok   = {1'b0, sel_addr} < RD_LIMIT;
    end

    // Next-state and registered-output logic. The enables and response
    // signals are computed here for the *next* cycle so that every output is
    // driven straight from a flop. Response fields fall back to zero every
    // cycle and are only loaded on the transition into RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        resp_valid_d = 2'b00;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_d  = grant_idx;
                    owner_d = grant_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_write && sel_wr_ok) begin
                        state_d    = WR_HI;
                        cnt_d      = WR_LAST;
                        write_en_d = 1'b1;
                    end else if (!sel_write && sel_rd_ok) begin
                        state_d   = RD;
                        cnt_d     = RD_LAST;
                        read_en_d = 1'b1;
                    end else begin
                        // Out-of-range: skip the map entirely and answer
                        // with an error on the very next cycle.
                        state_d      = RESP;
                        resp_valid_d = 2'b01 << grant_idx;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '1;
                    end
                end
            end

            WR_HI: begin
                if (cnt_q == '0) begin
                    state_d = WR_LO;
                    cnt_d   = WR_LAST;
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    write_en_d = 1'b1;
                end
            end

            WR_LO: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 2'b01 << owner_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RD: begin
                if (cnt_q == '0) begin
                    // Last strobe cycle: capture the map's data for RESP.
                    state_d      = RESP;
                    resp_valid_d = 2'b01 << owner_q;
                    resp_rdata_d = read_data_i;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    read_en_d = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction in flight:
    // the enables drop on the following cycle and no response is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign addr_o       = addr_q;
    assign write_data_o = wdata_q;
    assign write_en_o   = write_en_q;
    assign read_en_o    = read_en_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule
